// File: rtl/mips_pkg.sv
// Shared constants for the MIPS register file slice: default widths and the
// index of the hardwired-zero register.
package mips_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int REG_ZERO   = 0;

endpackage

// File: rtl/mips_regfile_mp_read_port.sv
// One combinational read port: picks between the stored word and the two
// in-flight write ports (B over A over array), forces the zero register to 0,
// and masks the busy bit when the pending load is landing this very cycle.
module rf_read_port
    import mips_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] arr_data,
    input  logic              arr_busy,
    input  logic              wa_en,
    input  logic [ADDR_W-1:0] wa_addr,
    input  logic [DATA_W-1:0] wa_data,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] data,
    output logic              busy
);

    logic is_zero;
    logic wa_hit;
    logic wb_hit;

    assign is_zero = (ZERO_REG != 0) && (addr == ADDR_W'(REG_ZERO));
    assign wa_hit  = wa_en && (wa_addr == addr);
    assign wb_hit  = wb_en && (wb_addr == addr);

    // Write-through bypass: zero register first, then port B, then port A.
    always_comb begin
        data = arr_data;
        if (is_zero) begin
            data = '0;
        end else if (wb_hit) begin
            data = wb_data;
        end else if (wa_hit) begin
            data = wa_data;
        end
    end

    // A load completing this cycle already supplies the value, so not busy.
    assign busy = arr_busy && !(wb_hit && !is_zero);

endmodule

// File: rtl/mips_regfile_mp.sv
// Multi-ported MIPS register file: NUM_RD combinational read ports with
// write-through bypass, an ALU write port (A) and a load write port (B), plus
// a per-register scoreboard of outstanding loads with a registered count.
module mips_regfile_mp
    import mips_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wa_en,
    input  logic [ADDR_W-1:0]        wa_addr,
    input  logic [DATA_W-1:0]        wa_data,
    input  logic                     wb_en,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     sb_set,
    input  logic [ADDR_W-1:0]        sb_addr,
    output logic [ADDR_W:0]          pend_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_nxt;
    logic [ADDR_W:0]   cnt_q;
    logic              wa_ok;
    logic              wb_ok;
    logic              sb_ok;
    logic              cnt_inc;
    logic              cnt_dec;

    // Writes and scoreboard sets aimed at the zero register are dropped here.
    assign wa_ok = wa_en  && !((ZERO_REG != 0) && (wa_addr == ADDR_W'(REG_ZERO)));
    assign wb_ok = wb_en  && !((ZERO_REG != 0) && (wb_addr == ADDR_W'(REG_ZERO)));
    assign sb_ok = sb_set && !((ZERO_REG != 0) && (sb_addr == ADDR_W'(REG_ZERO)));

    // Array update; B is assigned last so it wins a same-address collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wa_ok) begin
                regs[wa_addr] <= wa_data;
            end
            if (wb_ok) begin
                regs[wb_addr] <= wb_data;
            end
        end
    end

    // Next scoreboard: a load return clears, a new issue sets and wins.
    always_comb begin
        busy_nxt = busy;
        if (wb_ok) begin
            busy_nxt[wb_addr] = 1'b0;
        end
        if (sb_ok) begin
            busy_nxt[sb_addr] = 1'b1;
        end
    end

    // Count deltas taken from real bit transitions so the count tracks popcount.
    always_comb begin
        cnt_inc = sb_ok && !busy[sb_addr];
        cnt_dec = wb_ok && busy[wb_addr] && !(sb_ok && (sb_addr == wb_addr));
    end

    // Scoreboard bits and pending count; reset discards everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy  <= '0;
            cnt_q <= '0;
        end else begin
            busy <= busy_nxt;
            case ({cnt_inc, cnt_dec})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign pend_cnt = cnt_q;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr_k;
        assign addr_k = rd_addr[k*ADDR_W +: ADDR_W];

        rf_read_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG)
        ) u_rp (
            .addr     (addr_k),
            .arr_data (regs[addr_k]),
            .arr_busy (busy[addr_k]),
            .wa_en    (wa_en),
            .wa_addr  (wa_addr),
            .wa_data  (wa_data),
            .wb_en    (wb_en),
            .wb_addr  (wb_addr),
            .wb_data  (wb_data),
            .data     (rd_data[k*DATA_W +: DATA_W]),
            .busy     (rd_busy[k])
        );
    end

endmodule

// File: doc/mips_regfile_mp.md
MIPS_REGFILE_MP -- requirements
Module: mips_regfile_mp

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning register width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning address width; depth = 2**ADDR_W.
REQ-003 The block SHALL have parameter NUM_RD, default 2, meaning number of read ports, legal range 1..4.
REQ-004 The block SHALL have parameter ZERO_REG, default 1, meaning entry 0 is hardwired to zero.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port rd_addr, input, NUM_RD*ADDR_W bits: packed read addresses, port k in slice k.
REQ-008 The block SHALL have port rd_data, output, NUM_RD*DATA_W bits: packed read data.
REQ-009 The block SHALL have port rd_busy, output, NUM_RD bits: the addressed entry has a pending write.
REQ-010 The block SHALL have ports wa_en (1), wa_addr (ADDR_W) and wa_data (DATA_W), inputs: write port A, the ALU path.
REQ-011 The block SHALL have ports wb_en (1), wb_addr (ADDR_W) and wb_data (DATA_W), inputs: write port B, the load/long-latency path.
REQ-012 The block SHALL have ports sb_set (1) and sb_addr (ADDR_W), inputs: marks an entry pending for port B.
REQ-013 The block SHALL have port pend_cnt, output, ADDR_W+1 bits: the count of set busy bits.

Function
REQ-014 Writes SHALL commit on the rising clk edge when the enable is high; the array is unchanged otherwise.
REQ-015 When wa_en and wb_en target the same address in one cycle, port B data SHALL be stored.
REQ-016 Reads SHALL be combinational, with 0-cycle write-through bypass.
REQ-017 Bypass priority SHALL be: wb match, then wa match, then array contents.
REQ-018 With ZERO_REG=1, writes to entry 0 SHALL be ignored, reads of entry 0 SHALL return 0 including on bypass, and entry 0 SHALL never be busy.
REQ-019 The scoreboard SHALL keep one busy bit per entry.
REQ-020 sb_set SHALL set busy[sb_addr] at the next edge.
REQ-021 A wb_en write SHALL clear busy[wb_addr] at the same edge.
REQ-022 When set and clear hit the same address in one cycle, set SHALL win, because it is a new issue.
REQ-023 Port A writes SHALL NOT affect busy bits.
REQ-024 rd_busy[k] SHALL equal busy[rd_addr_k] AND NOT (wb_en AND wb_addr==rd_addr_k AND address non-zero under ZERO_REG).
REQ-025 pend_cnt SHALL be registered.
REQ-026 pend_cnt SHALL equal the popcount of busy after each edge, ranging 0..2**ADDR_W.
REQ-027 pend_cnt SHALL change by at most +1 or -1 per cycle.
REQ-028 pend_cnt SHALL be unchanged on a same-address set+clear, or when a set targets an entry already busy.

Reset
REQ-029 rst_n low SHALL immediately clear all 2**ADDR_W entries, including the highest index, clear all busy bits, and set pend_cnt to 0.
REQ-030 While rst_n is low, rd_data SHALL read 0 unless bypassed, rd_busy SHALL be 0, and writes SHALL be ignored.
REQ-031 Reset asserted mid-operation SHALL discard pending scoreboard state with no partial update.

Structure
REQ-032 A shared package mips_pkg SHALL hold DATA_W/ADDR_W defaults and the REG_ZERO constant.
REQ-033 The read-bypass mux SHALL be one sub-module, rf_read_port, instantiated NUM_RD times by generate.

Verification
REQ-034 The bench SHALL check: reset, then read of every address -> all 0 including address 31; pend_cnt=0.
REQ-035 The bench SHALL check: wa write 0xDEADBEEF to r5 while rd_addr0=5 in the same cycle -> rd_data0=0xDEADBEEF that cycle and after the edge.
REQ-036 The bench SHALL check: wa writes 0x1 and wb writes 0x2 to r7 in the same cycle -> bypass and stored value both 0x2.
REQ-037 The bench SHALL check: write 0xFFFFFFFF to r0 on both ports -> rd_data reads 0, busy[0] stays 0.
REQ-038 The bench SHALL check: sb_set r9, then r9 and r9 again -> pend_cnt 1; wb r9 with sb_set r9 in the same cycle -> busy stays 1, pend_cnt 1; wb r9 alone -> pend_cnt 0; rd_busy drops in the wb cycle.
REQ-039 The bench SHALL check: set busy on r1..r4, then pulse rst_n low between edges -> pend_cnt=0 and rd_busy=0 immediately, without a clock edge.
